// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 arbiter with burst locking and a single registered output stage.
// A burst (beats up to and including last=1) from one requester is never interleaved with another's.
module rr_mux_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_vld,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]       req_last,
    output logic [N_REQ-1:0]       req_rdy,
    output logic                   out_vld,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last,
    output logic [SEL_W-1:0]       out_src,
    input  logic                   out_rdy
);

    typedef enum logic {ARB, LOCK} state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] owner_q, owner_d;

    logic [SEL_W-1:0] arb_grant;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] sel_next;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic             any_vld;
    logic             pipe_rdy;
    logic             xfer;

    logic             out_vld_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_last_q;
    logic [SEL_W-1:0] out_src_q;

    // Search from ptr upwards, wrapping at N_REQ (not at 2**SEL_W) so odd sizes work.
    always_comb begin : grant_search
        logic [SEL_W:0] cand;
        logic           found;
        arb_grant = ptr_q;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_q} + (SEL_W+1)'(k);
            if (cand >= (SEL_W+1)'(N_REQ)) begin
                cand = cand - (SEL_W+1)'(N_REQ);
            end
            if (!found && req_vld[cand[SEL_W-1:0]]) begin
                found     = 1'b1;
                arb_grant = cand[SEL_W-1:0];
            end
        end
    end

    assign any_vld  = |req_vld;
    assign pipe_rdy = !out_vld_q || out_rdy;
    assign sel      = (state_q == LOCK) ? owner_q : arb_grant;
    assign sel_data = req_data[sel*WIDTH +: WIDTH];
    assign sel_last = req_last[sel];
    assign sel_next = (sel == SEL_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
    assign xfer     = req_vld[sel] && req_rdy[sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (xfer) begin
            if (sel_last) begin
                state_d = ARB;
                ptr_d   = sel_next;
            end else begin
                state_d = LOCK;
                owner_d = sel;
            end
        end
    end

    // While locked the owner keeps the grant even with req_vld low, so bubbles never let others in.
    always_comb begin
        req_rdy = '0;
        if (!rst && (state_q == LOCK || any_vld)) begin
            req_rdy[sel] = pipe_rdy;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            out_src_q  <= '0;
        end else if (xfer) begin
            out_vld_q  <= 1'b1;
            out_data_q <= sel_data;
            out_last_q <= sel_last;
            out_src_q  <= sel;
        end else if (out_rdy) begin
            out_vld_q  <= 1'b0;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign out_last = out_last_q;
    assign out_src  = out_src_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: a 4-requester and a 3-requester instance checked against a
// transaction-level arbitration model, with directed scenarios followed by random traffic.
module tb_rr_mux_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic outRdy;
    always #5 clk = ~clk;

    logic [3:0]  sVld  [2];
    logic [3:0]  sLast [2];
    logic [31:0] sData [2];
    logic [3:0]  acc   [2];

    logic [3:0]  rdy4;
    logic        oVld4, oLast4;
    logic [7:0]  oData4;
    logic [1:0]  oSrc4;
    logic [2:0]  rdy3;
    logic        oVld3, oLast3;
    logic [7:0]  oData3;
    logic [1:0]  oSrc3;

    rr_mux_arbiter #(.N_REQ(4), .WIDTH(8)) dut4 (
        .clk(clk), .rst(rst),
        .req_vld(sVld[0]), .req_data(sData[0]), .req_last(sLast[0]), .req_rdy(rdy4),
        .out_vld(oVld4), .out_data(oData4), .out_last(oLast4), .out_src(oSrc4),
        .out_rdy(outRdy)
    );

    rr_mux_arbiter #(.N_REQ(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst(rst),
        .req_vld(sVld[1][2:0]), .req_data(sData[1][23:0]), .req_last(sLast[1][2:0]), .req_rdy(rdy3),
        .out_vld(oVld3), .out_data(oData3), .out_last(oLast3), .out_src(oSrc3),
        .out_rdy(outRdy)
    );

    int checks = 0;
    int errors = 0;

    int         mPtr     [2];
    int         mOwner   [2];
    bit         mLock    [2];
    bit         mOutVld  [2];
    logic [7:0] mOutData [2];
    bit         mOutLast [2];
    int         mOutSrc  [2];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int nReq(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    function automatic logic [3:0] obsRdy(input int i);
        return (i == 0) ? rdy4 : {1'b0, rdy3};
    endfunction

    function automatic logic obsVld(input int i);
        return (i == 0) ? oVld4 : oVld3;
    endfunction

    function automatic logic [7:0] obsData(input int i);
        return (i == 0) ? oData4 : oData3;
    endfunction

    function automatic logic obsLast(input int i);
        return (i == 0) ? oLast4 : oLast3;
    endfunction

    function automatic logic [1:0] obsSrc(input int i);
        return (i == 0) ? oSrc4 : oSrc3;
    endfunction

    // Whoever may be served this cycle: the lock owner, else the first valid at or after ptr.
    function automatic int modelGrant(input int i);
        if (mLock[i]) return mOwner[i];
        for (int k = 0; k < nReq(i); k++) begin
            if (sVld[i][(mPtr[i] + k) % nReq(i)]) return (mPtr[i] + k) % nReq(i);
        end
        return -1;
    endfunction

    task automatic resetModel();
        for (int i = 0; i < 2; i++) begin
            mPtr[i] = 0; mOwner[i] = 0; mLock[i] = 0;
            mOutVld[i] = 0; mOutData[i] = 8'h00; mOutLast[i] = 0; mOutSrc[i] = 0;
        end
    endtask

    // Entered at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic applyStimulus();
        int         g;
        logic [3:0] er;
        #4;
        for (int i = 0; i < 2; i++) begin
            g  = modelGrant(i);
            er = 4'b0000;
            if (g >= 0 && (!mOutVld[i] || outRdy)) er[g] = 1'b1;
            checkOutput($sformatf("req_rdy[%0d]", i), 32'(obsRdy(i)), 32'(er));
            acc[i] = 4'b0000;
            if (g >= 0 && er[g] && sVld[i][g]) begin
                acc[i][g]   = 1'b1;
                mOutVld[i]  = 1;
                mOutData[i] = sData[i][g*8 +: 8];
                mOutLast[i] = sLast[i][g];
                mOutSrc[i]  = g;
                if (sLast[i][g]) begin
                    mPtr[i]  = (g + 1) % nReq(i);
                    mLock[i] = 0;
                end else begin
                    mLock[i]  = 1;
                    mOwner[i] = g;
                end
            end else if (outRdy) begin
                mOutVld[i] = 0;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("out_vld[%0d]", i), 32'(obsVld(i)), 32'(mOutVld[i]));
            checkOutput($sformatf("out_data[%0d]", i), 32'(obsData(i)), 32'(mOutData[i]));
            checkOutput($sformatf("out_last[%0d]", i), 32'(obsLast(i)), 32'(mOutLast[i]));
            checkOutput($sformatf("out_src[%0d]", i), 32'(obsSrc(i)), 32'(mOutSrc[i]));
        end
    endtask

    // Reset takes effect asynchronously; released at a posedge+1 so stimulus stays aligned.
    task automatic applyReset();
        rst = 1'b1;
        #1;
        resetModel();
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("rst out_vld[%0d]", i), 32'(obsVld(i)), 32'd0);
            checkOutput($sformatf("rst req_rdy[%0d]", i), 32'(obsRdy(i)), 32'd0);
            checkOutput($sformatf("rst out_src[%0d]", i), 32'(obsSrc(i)), 32'd0);
        end
        @(posedge clk);
        #1;
        checkOutput("rst hold req_rdy", 32'(obsRdy(0)), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] burstData [5];
        logic       burstVld  [5];
        logic       burstLast [5];
        logic [1:0] burstSrc  [5];
        logic [1:0] wrapExp   [4];

        rst    = 1'b0;
        outRdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sVld[i] = '0; sLast[i] = '0; sData[i] = '0; acc[i] = '0;
        end
        resetModel();
        #2;

        $display("[TB] reset with all requesters valid");
        sVld[0] = 4'b1111;
        sVld[1] = 4'b0111;
        applyReset();

        $display("[TB] round robin of single-beat bursts");
        sVld[1]  = 4'b0000;
        sLast[0] = 4'b1111;
        sData[0] = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int c = 0; c < 5; c++) begin
            applyStimulus();
            checkOutput($sformatf("rr src %0d", c), 32'(oSrc4), 32'(c % 4));
            checkOutput($sformatf("rr data %0d", c), 32'(oData4), 32'(8'h10 + (c % 4)));
        end

        $display("[TB] burst lock with bubbles");
        burstVld  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        burstLast = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        burstData = '{8'hA1, 8'hA1, 8'hA1, 8'hA2, 8'hA3};
        sVld[0]  = 4'b0101;
        sLast[0] = 4'b0101;
        for (int c = 0; c < 5; c++) begin
            sVld[0][1]       = burstVld[c];
            sLast[0][1]      = burstLast[c];
            sData[0][15:8]   = burstData[c];
            applyStimulus();
            checkOutput($sformatf("lock vld %0d", c), 32'(oVld4), 32'(burstVld[c]));
            if (burstVld[c]) begin
                checkOutput($sformatf("lock src %0d", c), 32'(oSrc4), 32'd1);
                checkOutput($sformatf("lock data %0d", c), 32'(oData4), 32'(burstData[c]));
            end
        end
        sVld[0][1] = 1'b0;
        applyStimulus();
        checkOutput("after lock src", 32'(oSrc4), 32'd2);

        $display("[TB] backpressure");
        sVld[0]  = 4'b1111;
        sLast[0] = 4'b1111;
        outRdy   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus();
            checkOutput("bp req_rdy", 32'(rdy4), 32'd0);
            checkOutput("bp src hold", 32'(oSrc4), 32'd2);
            checkOutput("bp vld hold", 32'(oVld4), 32'd1);
        end
        outRdy = 1'b1;
        applyStimulus();
        checkOutput("bp release src", 32'(oSrc4), 32'd3);
        checkOutput("bp release vld", 32'(oVld4), 32'd1);

        $display("[TB] wrap with three requesters");
        sVld[0]  = 4'b0000;
        sVld[1]  = 4'b0010;
        sLast[1] = 4'b0111;
        sData[1] = {8'h00, 8'h32, 8'h31, 8'h30};
        applyStimulus();
        sVld[1] = 4'b0101;
        wrapExp = '{2'd2, 2'd0, 2'd2, 2'd0};
        for (int c = 0; c < 4; c++) begin
            applyStimulus();
            checkOutput($sformatf("wrap src %0d", c), 32'(oSrc3), 32'(wrapExp[c]));
        end

        $display("[TB] reset in the middle of a burst");
        sVld[1]  = 4'b0000;
        sVld[0]  = 4'b1000;
        sLast[0] = 4'b0000;
        burstSrc = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
        for (int c = 0; c < 2; c++) begin
            sData[0][31:24] = 8'hC1 + 8'(c);
            applyStimulus();
            checkOutput($sformatf("mid src %0d", c), 32'(oSrc4), 32'(burstSrc[c]));
        end
        sVld[0] = 4'b1001;
        applyReset();
        sLast[0] = 4'b0001;
        applyStimulus();
        checkOutput("post reset grant", 32'(oSrc4), 32'd0);

        $display("[TB] random traffic");
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < nReq(i); k++) begin
                    if (!(sVld[i][k] && !acc[i][k])) begin
                        sVld[i][k]          = ($urandom_range(0, 3) != 0);
                        sLast[i][k]         = ($urandom_range(0, 2) == 0);
                        sData[i][k*8 +: 8]  = 8'($urandom);
                    end
                end
            end
            outRdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                applyReset();
                for (int i = 0; i < 2; i++) acc[i] = '0;
            end else begin
                applyStimulus();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
Round-robin arbiter that shares one WIDTH-bit output channel among N_REQ requesters through a select-driven N:1 data mux. Each requester presents valid/ready/last beats. A burst, which ends at the beat with last=1, is never interleaved with another requester's burst. The selected beat is captured in a single registered output stage with valid/ready handshake. The block sits between parallel producer lanes and a single shared consumer.

Parameters:
N_REQ, 4, number of requesters (>=2; need not be a power of two)
WIDTH, 8, data width per beat
SEL_W, $clog2(N_REQ), width of grant/source index (derived; do not override)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req_vld  input  N_REQ  per-requester beat valid
req_data  input  N_REQ*WIDTH  packed beats, requester k in bits [k*WIDTH +: WIDTH]
req_last  input  N_REQ  per-requester end-of-burst flag, qualified by req_vld
req_rdy  output  N_REQ  per-requester accept (combinational, at most one bit high)
out_vld  output  1  registered output beat valid
out_data  output  WIDTH  registered output beat
out_last  output  1  registered end-of-burst flag
out_src  output  SEL_W  index of requester that produced the current out beat
out_rdy  input  1  consumer accept

Behaviour:
- pipe_rdy = !out_vld || out_rdy. A beat transfers from requester g when req_vld[g] && req_rdy[g].
- Reset (async, immediate) values:
  - state=ARB, ptr=0, owner=0.
  - out_vld=0, out_data=0, out_last=0, out_src=0.
  - req_rdy forced all-zero while rst is high.
- ARB state:
  - Grant g = first index with req_vld high, searching circularly from ptr (ptr, ptr+1, ..., wrapping N_REQ-1 -> 0).
  - If any req_vld is high: req_rdy[g]=pipe_rdy, other bits 0. If no req_vld is high: req_rdy=0.
  - On transfer with req_last[g]=1: ptr<=(g+1) mod N_REQ, stay in ARB.
  - On transfer with req_last[g]=0: owner<=g, go to LOCK.
  - Without a transfer, ptr does not move.
- LOCK state:
  - req_rdy[owner]=pipe_rdy, all other bits 0.
  - Other requesters are never served, even if the owner's req_vld is low (bubbles allowed).
  - On owner transfer with last=1: ptr<=(owner+1) mod N_REQ, go to ARB.
- Output stage, on a transfer:
  - out_data<=req_data[g], out_last<=req_last[g], out_src<=g, out_vld<=1.
  - Else if out_rdy: out_vld<=0; data, last and src hold.
  - Output holds stable while out_vld && !out_rdy.
- Latency: 1 cycle from transfer to out_vld. Throughput: 1 beat/cycle with out_rdy held high.
- Simultaneous output drain and new transfer in one cycle: the new beat overwrites, out_vld stays 1, no beat is lost or duplicated.
- req_data and req_last of non-granted requesters are don't-care. A requester's data must stay stable while its req_vld=1 and req_rdy=0 (producer rule; not checked by this block).
- Reset mid-burst: in-flight output beat dropped, lock released, ptr returns to 0.
- Wrap: a grant to N_REQ-1 sets ptr to 0. The search wraps correctly for non-power-of-two N_REQ (e.g. 3).

Test Plan:
- Reset check: assert rst with req_vld=4'b1111 -> out_vld=0, req_rdy=0000, out_src=0. Release rst: first grant goes to requester 0.
- Round robin: all four requesters send single-beat bursts (last=1, data=8'h10+k), out_rdy=1 -> out_src order 0,1,2,3,0. One beat per cycle, out_data matches, 1-cycle latency.
- Burst lock: requester 1 sends 3 beats (A1,A2,A3, last on A3) while 0 and 2 are continuously valid. Requester 1 drops valid for 2 cycles mid-burst -> out beats A1,A2,A3 are contiguous with src=1, no other src in between; next grant goes to 2.
- Backpressure: out_rdy=0 for 5 cycles while out_vld=1 -> out_data, out_src and out_last held stable, req_rdy=0000. Raise out_rdy -> next beat is accepted in the same cycle, out_vld stays high.
- Wrap and non-power-of-two: N_REQ=3, only requesters 2 and 0 valid, ptr=2 -> grant order 2,0,2,0; out_src never 1 or 3.
- Reset mid-burst: rst asserted after 2nd of 4 beats of requester 3 -> out_vld drops immediately. After release, requester 0 (valid) is granted even though requester 3 remains valid.
